// File: rtl/micron_async_mem_ctrl_if.sv
// System-side request/response bundle for the async memory controller.
// The master issues requests; the controller (slave) answers with ready/done/rdata.
interface micron_async_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic        ready;
    logic        done;
    logic [15:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ready, done, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ready, done, rdata
    );
endinterface

// File: rtl/micron_async_mem_ctrl.sv
// Asynchronous-mode controller for Micron CellularRAM-style PSRAM.
// One request per IDLE->SETUP->ACCESS->RECOVER pass; no queueing.
module micron_async_mem_ctrl #(
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    micron_async_mem_ctrl_if.slave sys,
    output logic                   mclk,
    output logic                   mcre,
    output logic                   mce_L,
    output logic                   moe_L,
    output logic                   mwe_L,
    output logic                   madv_L,
    output logic                   mub_L,
    output logic                   mlb_L,
    output logic [22:0]            maddr,
    inout  wire  [15:0]            mem_data
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETUP   = 2'd1;
    localparam logic [1:0] ACCESS  = 2'd2;
    localparam logic [1:0] RECOVER = 2'd3;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE: begin
                if (sys.req) begin
                    we_d    = sys.we;
                    addr_d  = sys.addr;
                    wdata_d = sys.wdata;
                    be_d    = sys.be;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                cnt_d   = CNT_INIT;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) rdata_d = mem_data;
                    state_d = RECOVER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RECOVER: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= 2'b00;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
        end
    end

    logic active;
    logic drive;

    // Chip is selected during SETUP and ACCESS only; RECOVER deselects it.
    assign active = (state_q == SETUP) || (state_q == ACCESS);
    // Write data is held through RECOVER to cover the device hold time.
    assign drive  = we_q && ((state_q == ACCESS) || (state_q == RECOVER));

    assign mclk     = 1'b0;
    assign mcre     = 1'b0;
    assign mce_L    = ~active;
    assign madv_L   = ~active;
    assign mub_L    = ~(active && be_q[1]);
    assign mlb_L    = ~(active && be_q[0]);
    assign moe_L    = ~((state_q == ACCESS) && !we_q);
    assign mwe_L    = ~((state_q == ACCESS) && we_q);
    assign maddr    = addr_q;
    assign mem_data = drive ? wdata_q : 16'hzzzz;

    assign sys.ready = (state_q == IDLE);
    assign sys.done  = (state_q == RECOVER);
    assign sys.rdata = rdata_q;

endmodule

// File: tb/tb_micron_async_mem_ctrl.sv
// Directed-vector bench for micron_async_mem_ctrl with a small PSRAM model.
// Default WAIT_CYCLES=4: done 6 cycles after acceptance edge, ready at 7.
module tb_micron_async_mem_ctrl;

    localparam int W = 4;

    logic        clk;
    logic        rst;
    logic        mclk, mcre;
    logic        mce_L, moe_L, mwe_L, madv_L, mub_L, mlb_L;
    logic [22:0] maddr;
    wire  [15:0] mem_data;

    micron_async_mem_ctrl_if intf ();

    micron_async_mem_ctrl #(.WAIT_CYCLES(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sys      (intf.slave),
        .mclk     (mclk),
        .mcre     (mcre),
        .mce_L    (mce_L),
        .moe_L    (moe_L),
        .mwe_L    (mwe_L),
        .madv_L   (madv_L),
        .mub_L    (mub_L),
        .mlb_L    (mlb_L),
        .maddr    (maddr),
        .mem_data (mem_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    logic [15:0] mem [0:15];

    assign mem_data = (!mce_L && !moe_L) ? mem[maddr[3:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (!mce_L && !mwe_L) begin
            if (!mub_L) mem[maddr[3:0]][15:8] <= mem_data[15:8];
            if (!mlb_L) mem[maddr[3:0]][7:0]  <= mem_data[7:0];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] ctl();
        return {mce_L, moe_L, mwe_L, madv_L, mub_L, mlb_L};
    endfunction

    int n_we, n_oe, n_done, done_i, ready_i, n_ub, n_lb, n_ma, n_bus;
    bit setup_ok;

    task automatic run_txn(input logic w, input logic [22:0] a,
                           input logic [15:0] d, input logic [1:0] b,
                           input bit busy);
        intf.we    = w;
        intf.addr  = a;
        intf.wdata = d;
        intf.be    = b;
        intf.req   = 1'b1;
        tick();
        intf.req   = 1'b0;
        intf.we    = ~w;
        intf.addr  = ~a;
        intf.wdata = ~d;
        intf.be    = ~b;
        n_we = 0; n_oe = 0; n_done = 0; done_i = 0; ready_i = 0;
        n_ub = 0; n_lb = 0; n_ma = 0; n_bus = 0; setup_ok = 0;
        for (int i = 1; i <= W + 3; i++) begin
            if (!mwe_L) n_we++;
            if (!moe_L) n_oe++;
            if (intf.done) begin n_done++; done_i = i; end
            if (intf.ready && ready_i == 0) ready_i = i;
            if (!mub_L) n_ub++;
            if (!mlb_L) n_lb++;
            if (i <= W + 2 && maddr == a) n_ma++;
            if (w && i >= 2 && i <= W + 2 && mem_data == d) n_bus++;
            if (i == 1 && ctl()[5:2] == 4'b0110) setup_ok = 1;
            if (busy && i == 3) begin
                intf.req  = 1'b1;
                intf.addr = 23'h9;
            end
            if (busy && i == 4) intf.req = 1'b0;
            tick();
        end
    endtask

    logic        bw_we   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [22:0] bw_addr [4] = '{23'h5, 23'h5, 23'h6, 23'h6};
    logic [15:0] bw_dat  [4] = '{16'hBEEF, 16'h0, 16'h1111, 16'h0};

    initial begin
        int n_rdy, n_dn, bad;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0;
        mem[4] = 16'h7E7E;
        intf.req = 0; intf.we = 0; intf.addr = '0;
        intf.wdata = '0; intf.be = 2'b00;
        rst = 1'b1;
        tick(); tick();

        chk("rst_ready", 32'(intf.ready), 32'h1);
        chk("rst_done", 32'(intf.done), 32'h0);
        chk("rst_rdata", 32'(intf.rdata), 32'h0);
        chk("rst_maddr", 32'(maddr), 32'h0);
        chk("rst_ctl", 32'(ctl()), 32'h3F);
        chk("rst_mclk_mcre", 32'({mclk, mcre}), 32'h0);
        rst = 1'b0;
        tick();

        run_txn(1'b1, 23'h3, 16'hA5C3, 2'b11, 0);
        chk("wr_setup", 32'(setup_ok), 32'h1);
        chk("wr_we_low", 32'(n_we), 32'(W));
        chk("wr_oe_low", 32'(n_oe), 32'h0);
        chk("wr_bus", 32'(n_bus), 32'(W + 1));
        chk("wr_done_cnt", 32'(n_done), 32'h1);
        chk("wr_done_at", 32'(done_i), 32'(W + 2));
        chk("wr_ready_at", 32'(ready_i), 32'(W + 3));
        chk("wr_maddr", 32'(n_ma), 32'(W + 2));
        chk("wr_mem", 32'(mem[3]), 32'hA5C3);

        run_txn(1'b0, 23'h3, 16'h0000, 2'b11, 0);
        chk("rd_oe_low", 32'(n_oe), 32'(W));
        chk("rd_we_low", 32'(n_we), 32'h0);
        chk("rd_done_at", 32'(done_i), 32'(W + 2));
        chk("rd_rdata", 32'(intf.rdata), 32'hA5C3);

        run_txn(1'b1, 23'h3, 16'h1234, 2'b01, 0);
        chk("bw_ub", 32'(n_ub), 32'h0);
        chk("bw_lb", 32'(n_lb), 32'(W + 1));
        chk("bw_rdata_kept", 32'(intf.rdata), 32'hA5C3);
        run_txn(1'b0, 23'h3, 16'h0000, 2'b11, 0);
        chk("bw_readback", 32'(intf.rdata), 32'hA534);

        run_txn(1'b0, 23'h4, 16'h0000, 2'b00, 0);
        chk("be0_ub_lb", 32'(n_ub + n_lb), 32'h0);
        chk("be0_done", 32'(n_done), 32'h1);
        chk("be0_rdata", 32'(intf.rdata), 32'h7E7E);

        n_rdy = 0; n_dn = 0;
        intf.req = 1'b1;
        intf.be  = 2'b11;
        for (int i = 0; i < 7 * 4; i++) begin
            if (intf.ready) begin
                if (n_rdy < 4) begin
                    intf.we    = bw_we[n_rdy];
                    intf.addr  = bw_addr[n_rdy];
                    intf.wdata = bw_dat[n_rdy];
                end
                n_rdy++;
            end
            if (intf.done) n_dn++;
            tick();
        end
        intf.req = 1'b0;
        tick(); tick();
        chk("b2b_ready", 32'(n_rdy), 32'h4);
        chk("b2b_done", 32'(n_dn), 32'h4);
        chk("b2b_mem5", 32'(mem[5]), 32'hBEEF);
        chk("b2b_rdata", 32'(intf.rdata), 32'h1111);

        run_txn(1'b0, 23'h3, 16'h0000, 2'b11, 1);
        chk("busy_maddr", 32'(n_ma), 32'(W + 2));
        chk("busy_done", 32'(n_done), 32'h1);
        n_dn = 0;
        for (int i = 0; i < 10; i++) begin
            if (intf.done) n_dn++;
            tick();
        end
        chk("busy_no_extra", 32'(n_dn), 32'h0);

        intf.we = 1'b1; intf.addr = 23'h7;
        intf.wdata = 16'hCAFE; intf.be = 2'b11;
        intf.req = 1'b1;
        tick();
        intf.req = 1'b0;
        tick(); tick();
        rst = 1'b1;
        intf.req = 1'b1;
        tick();
        chk("mid_rst_ctl", 32'(ctl()), 32'h3F);
        chk("mid_rst_ready", 32'(intf.ready), 32'h1);
        chk("mid_rst_done", 32'(intf.done), 32'h0);
        chk("mid_rst_rdata", 32'(intf.rdata), 32'h0);
        chk("mid_rst_maddr", 32'(maddr), 32'h0);
        rst = 1'b0;
        intf.req = 1'b0;
        n_dn = 0; bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (intf.done) n_dn++;
            if (ctl() != 6'h3F) bad++;
            tick();
        end
        chk("mid_rst_no_done", 32'(n_dn), 32'h0);
        chk("mid_rst_quiet", 32'(bad), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/micron_async_mem_ctrl.md
MICRON_ASYNC_MEM_CTRL -- requirements
Module: micron_async_mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 4, meaning number of clk cycles the OE_L/WE_L strobe is held low (4 x 20 ns = 80 ns at 50 MHz); legal range 1..15.
REQ-002 clk  input  1  sole clock, all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  1  request strobe from system side, sampled only when ready=1.
REQ-005 we  input  1  1=write, 0=read; sampled with req.
REQ-006 addr  input  23  word address; sampled with req.
REQ-007 wdata  input  16  write data; sampled with req.
REQ-008 be  input  2  byte enables, be[1]=upper byte, be[0]=lower byte, active-high; sampled with req.
REQ-009 ready  output  1  controller idle, request will be accepted this cycle.
REQ-010 done  output  1  one-cycle pulse marking transaction completion.
REQ-011 rdata  output  16  read data, valid from done pulse until next read completes.
REQ-012 mce_L, moe_L, mwe_L, madv_L, mub_L, mlb_L  output  1 each  active-low memory controls.
REQ-013 mclk, mcre  output  1 each  memory clock and configuration-register enable.
REQ-014 maddr  output  23  memory address (bits 22:0; top pin tied low at board level).
REQ-015 mem_data  inout  16  memory data bus, tristated when not driving.

Function
REQ-016 States: IDLE, SETUP, ACCESS, RECOVER; ready=1 only in IDLE.
REQ-017 IDLE with req=1 -> latch we/addr/wdata/be, go to SETUP; req=0 -> stay IDLE.
REQ-018 SETUP, 1 cycle: mce_L=0, madv_L=0, maddr=latched addr, mub_L=~be[1], mlb_L=~be[0]; moe_L=mwe_L=1.
REQ-019 ACCESS, exactly WAIT_CYCLES cycles via down-counter: SETUP controls held; read -> moe_L=0; write -> mwe_L=0, mem_data driven with latched wdata.
REQ-020 Read: rdata captured from mem_data at the rising edge ending the last ACCESS cycle.
REQ-021 RECOVER, 1 cycle: mce_L=moe_L=mwe_L=madv_L=mub_L=mlb_L=1, done=1; write data still driven (hold time); read leaves bus tristated; next state IDLE.
REQ-022 Latency: req sampled at edge N -> SETUP in cycle N+1, ACCESS cycles N+2..N+1+WAIT_CYCLES, done=1 in cycle N+2+WAIT_CYCLES, ready=1 in cycle N+3+WAIT_CYCLES.
REQ-023 req while ready=0 ignored, never queued; req held high re-issues the held request on first IDLE cycle (back-to-back period WAIT_CYCLES+3).
REQ-024 Inputs may change after acceptance without effect on the transaction in flight.
REQ-025 be=2'b00: full cycle executed, mub_L=mlb_L=1 throughout, done still pulses; read still updates rdata.
REQ-026 Write transactions leave rdata unchanged.
REQ-027 mclk=0 and mcre=0 at all times (asynchronous mode, no config writes).
REQ-028 mem_data driven only in write ACCESS and write RECOVER; tristated in all other states.
REQ-029 maddr holds latched address from SETUP through RECOVER; 0 in IDLE after reset, otherwise last address.

Reset
REQ-030 rst=1 at an edge -> next cycle: state IDLE, ready=1, done=0, rdata=0, maddr=0, mce_L=moe_L=mwe_L=madv_L=mub_L=mlb_L=1, mem_data tristated, counter 0.
REQ-031 Reset in any state, including mid-ACCESS, aborts the transaction without done pulse; req ignored while rst=1.

Verification
REQ-032 Write: req=1, we=1, addr=0x000003, wdata=0xA5C3, be=2'b11 -> mwe_L low exactly 4 cycles, mem_data=0xA5C3 through RECOVER, done one cycle, ready back 7 cycles after acceptance.
REQ-033 Read-back: req=1, we=0, addr=0x000003 (memory model loaded) -> moe_L low 4 cycles, rdata=0xA5C3 at done, bus never driven by controller.
REQ-034 Byte write: be=2'b01, wdata=0x1234 to addr 3, then read addr 3 -> mlb_L low, mub_L high during write; rdata=0xA534.
REQ-035 Back-to-back: req held high, alternating we -> ready low except one cycle per 7-cycle period, no request lost, no extra done pulses.
REQ-036 Reset mid-operation: rst asserted in 2nd ACCESS cycle of a write -> next cycle all controls high, bus tristated, no done, ready=1, rdata=0.
REQ-037 Busy request: req pulsed with different addr during ACCESS -> ignored, maddr unchanged, exactly one done pulse.
